mux_nto1_rr_valid: RTL and testbench

Parametrised N-channel, WIDTH-bit multiplexer with per-channel valid/ready handshakes and a registered output stage. Channel selection is either the external selector or round-robin arbitration among the valid channels, chosen at run time. It is the successor to the 2:1 valid-qualified byte mux and sits between the lane sources and the downstream serialiser/FIFO in the datapath.

---
 rtl/mux_nto1_rr_valid_pkg.sv | 15 +
 rtl/mux_nto1_rr_valid_rr_arbiter_n.sv | 37 +++
 rtl/mux_nto1_rr_valid.sv | 94 +++++++++
 tb/tb_mux_nto1_rr_valid.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_nto1_rr_valid_pkg.sv
// Shared constants for the N:1 valid/ready channel mux: mode encodings, default sizes, selector-width helper.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam int DEFAULT_N_CH  = 4;
    localparam int DEFAULT_WIDTH = 8;

    // Selector/source-id width; never collapses to zero bits for tiny channel counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_rr_valid_rr_arbiter_n.sv
// Rotating-priority request scan starting at ptr, wrapping modulo N_CH.
// Latency: purely combinational, no state.
// Backpressure: none here; the caller qualifies the grant with its own accept.
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter  int N_CH  = DEFAULT_N_CH,
    localparam int SEL_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             grant_vld,
    output logic [SEL_W-1:0] grant
);

    int               idx;
    logic [SEL_W-1:0] idx_s;

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = 0;
        idx_s     = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            idx_s = idx[SEL_W-1:0];
            if (!grant_vld && req[idx_s]) begin
                grant_vld = 1'b1;
                grant     = idx_s;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_rr_valid.sv
// N-channel valid/ready mux, external-selector or round-robin grant, registered output (MUX_PARITY_EN adds parity_out).
// Latency: 1 cycle from input handshake to valid_out; 1 word/cycle with ready_down held high.
// Backpressure: valid_out && !ready_down stalls everything; no ready_in is raised while stalled or in reset.
module mux_nto1_rr_valid
    import mux_pkg::*;
#(
    parameter  int N_CH  = DEFAULT_N_CH,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int SEL_W = clog2_min1(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      selector,
    input  logic [N_CH-1:0]       valid_in,
    input  logic [N_CH*WIDTH-1:0] data_in,
    output logic [N_CH-1:0]       ready_in,
    input  logic                  ready_down,
    output logic                  valid_out,
    output logic [WIDTH-1:0]      data_out,
    output logic [SEL_W-1:0]      src_out
`ifdef MUX_PARITY_EN
    ,
    output logic                  parity_out
`endif
);

    logic [WIDTH-1:0] ch_dat [N_CH];
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_grant_vld;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic [WIDTH-1:0] grant_dat;
    logic             accept;
    logic             sel_ok;
    logic             xfer;
    logic [SEL_W-1:0] rr_ptr_nxt;

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_dat[i] = data_in[i*WIDTH +: WIDTH];
    end

    rr_arbiter_n #(
        .N_CH (N_CH)
    ) u_arb (
        .req       (valid_in),
        .ptr       (rr_ptr),
        .grant_vld (rr_grant_vld),
        .grant     (rr_grant)
    );

    always_comb begin
        accept = !valid_out || ready_down;
        // An out-of-range selector (non power-of-two N_CH) must never grant.
        sel_ok = int'(selector) < N_CH;
        if (mode == MODE_RR) begin
            grant     = rr_grant;
            grant_vld = rr_grant_vld;
        end else begin
            grant     = selector;
            grant_vld = sel_ok && valid_in[selector];
        end
        grant_dat  = ch_dat[grant];
        xfer       = !reset && accept && grant_vld;
        ready_in   = xfer ? (N_CH'(1) << grant) : '0;
        rr_ptr_nxt = (int'(grant) == N_CH - 1) ? '0 : grant + SEL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            src_out    <= '0;
            rr_ptr     <= '0;
`ifdef MUX_PARITY_EN
            parity_out <= 1'b0;
`endif
        end else if (accept) begin
            valid_out <= grant_vld;
            if (grant_vld) begin
                data_out   <= grant_dat;
                src_out    <= grant;
`ifdef MUX_PARITY_EN
                parity_out <= ^grant_dat;
`endif
                if (mode == MODE_RR) begin
                    rr_ptr <= rr_ptr_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_rr_valid.sv
// Directed bench: 4-channel instance plus a 5-channel instance for out-of-range selector handling.
module tb_mux_nto1_rr_valid;

    logic        clk;
    logic        reset;
    logic        mode;
    logic [1:0]  selector;
    logic [3:0]  valid_in;
    logic [7:0]  ch_dat [4];
    logic [31:0] data_in;
    logic [3:0]  ready_in;
    logic        ready_down;
    logic        valid_out;
    logic [7:0]  data_out;
    logic [1:0]  src_out;
`ifdef MUX_PARITY_EN
    logic        parity_out;
    logic        n5_parity;
`endif

    logic        n5_mode;
    logic [2:0]  n5_sel;
    logic [4:0]  n5_vld_in;
    logic [39:0] n5_dat_in;
    logic [4:0]  n5_rdy_in;
    logic        n5_vld_out;
    logic [7:0]  n5_dat_out;
    logic [2:0]  n5_src;

    int checks   = 0;
    int failures = 0;

    logic [9:0] sb_q [$];

    assign data_in   = {ch_dat[3], ch_dat[2], ch_dat[1], ch_dat[0]};
    assign n5_dat_in = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};

    mux_nto1_rr_valid #(.N_CH(4), .WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .selector   (selector),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .ready_in   (ready_in),
        .ready_down (ready_down),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .src_out    (src_out)
`ifdef MUX_PARITY_EN
        ,
        .parity_out (parity_out)
`endif
    );

    mux_nto1_rr_valid #(.N_CH(5), .WIDTH(8)) dut_n5 (
        .clk        (clk),
        .reset      (reset),
        .mode       (n5_mode),
        .selector   (n5_sel),
        .valid_in   (n5_vld_in),
        .data_in    (n5_dat_in),
        .ready_in   (n5_rdy_in),
        .ready_down (1'b1),
        .valid_out  (n5_vld_out),
        .data_out   (n5_dat_out),
        .src_out    (n5_src)
`ifdef MUX_PARITY_EN
        ,
        .parity_out (n5_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-word scoreboard: every input handshake must emerge exactly once, in order, unless reset flushes it.
    always @(posedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (valid_out && ready_down) begin
                check("sb_depth", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    check("sb_word", {src_out, data_out}, sb_q.pop_front());
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (ready_in[i] && valid_in[i]) begin
                    sb_q.push_back({2'(i), ch_dat[i]});
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        mode       = 1'b1;
        selector   = 2'd0;
        valid_in   = 4'hF;
        ready_down = 1'b1;
        for (int i = 0; i < 4; i++) ch_dat[i] = 8'h10 + 8'(i);
        n5_mode    = 1'b0;
        n5_sel     = 3'd7;
        n5_vld_in  = 5'h1F;

        // Reset with all channels valid
        step();
        step();
        check("rst_vld", valid_out, 0);
        check("rst_dat", data_out, 0);
        check("rst_src", src_out, 0);
        check("rst_rdy", ready_in, 0);
`ifdef MUX_PARITY_EN
        check("rst_par", parity_out, 0);
`endif
        reset = 1'b0;
        #1;
        check("n5_oor_rdy", n5_rdy_in, 0);

        // Round-robin over four always-valid channels
        for (int k = 0; k < 8; k++) begin
            check("rr_rdy", ready_in, 4'b0001 << (k % 4));
            step();
            check("rr_vld", valid_out, 1);
            check("rr_src", src_out, k % 4);
            check("rr_dat", data_out, 8'h10 + k % 4);
        end
        check("n5_oor_vld", n5_vld_out, 0);

        // External selector
        mode      = 1'b0;
        selector  = 2'd2;
        valid_in  = 4'b0100;
        ch_dat[2] = 8'hA5;
        #1;
        check("sel_rdy", ready_in, 4'b0100);
        step();
        check("sel_vld", valid_out, 1);
        check("sel_dat", data_out, 8'hA5);
        check("sel_src", src_out, 2);
        selector = 2'd1;
        #1;
        check("sel_nogrant_rdy", ready_in, 0);
        step();
        check("sel_nogrant_vld", valid_out, 0);
        check("sel_hold_dat", data_out, 8'hA5);
        check("sel_hold_src", src_out, 2);
        n5_sel = 3'd4;
        #1;
        check("n5_sel4_rdy", n5_rdy_in, 5'b10000);
        step();
        check("n5_sel4_vld", n5_vld_out, 1);
        check("n5_sel4_dat", n5_dat_out, 8'h44);
        check("n5_sel4_src", n5_src, 4);

        // Sparse round-robin: drive ptr to 3 then wrap
        ch_dat[2] = 8'h12;
        mode      = 1'b1;
        valid_in  = 4'b0100;
        #1;
        check("sp_rdy0", ready_in, 4'b0100);
        step();
        check("sp_src0", src_out, 2);
        valid_in = 4'b0011;
        #1;
        check("sp_rdy1", ready_in, 4'b0001);
        step();
        check("sp_src1", src_out, 0);
        check("sp_rdy2", ready_in, 4'b0010);
        step();
        check("sp_src2", src_out, 1);
        check("sp_rdy3", ready_in, 4'b0001);
        step();
        check("sp_src3", src_out, 0);

        // Backpressure stall (ptr = 1)
        valid_in = 4'hF;
        #1;
        check("bp_rdy_pre", ready_in, 4'b0010);
        step();
        check("bp_src_pre", src_out, 1);
        ready_down = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_rdy_stall", ready_in, 0);
            step();
            check("bp_vld_stall", valid_out, 1);
            check("bp_dat_stall", data_out, 8'h11);
            check("bp_src_stall", src_out, 1);
        end
        ready_down = 1'b1;
        #1;
        check("bp_rdy_release", ready_in, 4'b0100);
        step();
        check("bp_src_release", src_out, 2);
        check("bp_dat_release", data_out, 8'h12);

        // Mode switch mid-stream (ptr = 3)
        check("ms_rdy0", ready_in, 4'b1000);
        step();
        check("ms_src0", src_out, 3);
        check("ms_rdy1", ready_in, 4'b0001);
        step();
        check("ms_src1", src_out, 0);
        mode     = 1'b0;
        selector = 2'd3;
        #1;
        check("ms_sel_rdy", ready_in, 4'b1000);
        step();
        check("ms_sel_src", src_out, 3);
        mode = 1'b1;
        #1;
        check("ms_ptr_held_rdy", ready_in, 4'b0010);
        step();
        check("ms_ptr_held_src", src_out, 1);

        // Reset while holding a stalled word
        ready_down = 1'b0;
        reset      = 1'b1;
        #1;
        check("mr_rdy_stall", ready_in, 0);
        step();
        check("mr_vld", valid_out, 0);
        check("mr_dat", data_out, 0);
        check("mr_src", src_out, 0);
        ready_down = 1'b1;
        #1;
        check("mr_rdy_gated", ready_in, 0);
        step();
        reset     = 1'b0;
        ch_dat[0] = 8'h07;
        #1;
        check("mr_ptr_cleared", ready_in, 4'b0001);
        step();
        check("mr_post_src", src_out, 0);
        check("mr_post_dat", data_out, 8'h07);
`ifdef MUX_PARITY_EN
        check("par_07", parity_out, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
